// File: rtl/fp16_pkg.sv
// Shared fp16 definitions: field widths, exponent limits and a field splitter.
// Also holds the output buffer state type used by the packer.
package fp16_pkg;

    localparam int FP16_W      = 16;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;

    localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = 5'h1F;

    typedef struct packed {
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_FRAC_W-1:0] frac;
    } fp16_fields_t;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_FULL
    } buf_state_t;

    function automatic fp16_fields_t fp16_split(input logic [FP16_W-1:0] x);
        return fp16_fields_t'(x);
    endfunction

endpackage

// File: rtl/fp16_skid_fifo2.sv
// Two-entry valid/ready buffer; the head entry drives dout.
// in_ready depends on registered state only.
module fp16_skid_fifo2
    import fp16_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout
);

    buf_state_t   state;
    buf_state_t   state_nxt;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         pop;

    assign pop  = out_valid & out_ready;
    assign dout = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BUF_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BUF_EMPTY: if (push) state_nxt = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop)      state_nxt = BUF_FULL;
                else if (!push && pop) state_nxt = BUF_EMPTY;
            end
            BUF_FULL: if (pop) state_nxt = BUF_ONE;
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state != BUF_EMPTY);
        in_ready  = (state != BUF_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            unique case (state)
                BUF_EMPTY: if (push) head <= din;
                BUF_ONE: begin
                    if (push && pop) head <= din;
                    else if (push)   tail <= din;
                end
                BUF_FULL: if (pop) head <= tail;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fp16_sum_packer.sv
// Packs LANES consecutive fp16 results into one wide word with keep/last.
// Optional FP16_PACK_SPECIAL_EN adds a per-lane Inf/NaN flag (out_special).
module fp16_sum_packer
    import fp16_pkg::*;
#(
    parameter int          LANES = 4,
    parameter logic [15:0] PAD   = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FP16_W-1:0]       in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FP16_W*LANES-1:0] out_data,
    output logic [LANES-1:0]        out_keep,
`ifdef FP16_PACK_SPECIAL_EN
    output logic [LANES-1:0]        out_special,
`endif
    output logic                    out_last
);

    localparam int CW = $clog2(LANES);
    localparam int DW = FP16_W * LANES;
`ifdef FP16_PACK_SPECIAL_EN
    localparam int SW = LANES;
`else
    localparam int SW = 0;
`endif
    localparam int PW = DW + LANES + 1 + SW;

    logic [CW-1:0]     cnt;
    logic [FP16_W-1:0] stage [LANES];
    logic              accept;
    logic              close;
    logic [DW-1:0]     word_data;
    logic [LANES-1:0]  word_keep;
    logic [PW-1:0]     payload;
    logic [PW-1:0]     head;

    assign accept = in_valid & in_ready;
    assign close  = accept & (in_last | (cnt == CW'(LANES - 1)));

    // Lanes below cnt come from staging, lane cnt is the live result.
    always_comb begin
        word_data = '0;
        word_keep = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(cnt))
                word_data[i*FP16_W +: FP16_W] = stage[i];
            else if (i == int'(cnt))
                word_data[i*FP16_W +: FP16_W] = in_data;
            else
                word_data[i*FP16_W +: FP16_W] = PAD;
            word_keep[i] = (i <= int'(cnt));
        end
    end

`ifdef FP16_PACK_SPECIAL_EN
    logic [LANES-1:0] word_spec;

    always_comb begin
        word_spec = '0;
        for (int i = 0; i < LANES; i++) begin
            word_spec[i] = word_keep[i] &
                (fp16_split(word_data[i*FP16_W +: FP16_W]).exp == FP16_EXP_MAX);
        end
    end

    assign payload = {word_spec, in_last, word_keep, word_data};
    assign out_special = head[DW+LANES+1 +: LANES];
`else
    assign payload = {in_last, word_keep, word_data};
`endif

    assign out_data = head[0 +: DW];
    assign out_keep = head[DW +: LANES];
    assign out_last = head[DW+LANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < LANES; i++) stage[i] <= '0;
        end else if (accept) begin
            stage[cnt] <= in_data;
            if (close) cnt <= '0;
            else       cnt <= cnt + CW'(1);
        end
    end

    fp16_skid_fifo2 #(
        .W (PW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (close),
        .din       (payload),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (head)
    );

endmodule

// File: tb/tb_fp16_sum_packer.sv
// Randomized bench for fp16_sum_packer with a queue-based reference model.
// Build with FP16_PACK_SPECIAL_EN to also check out_special.
module tb_fp16_sum_packer;

    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
`ifdef FP16_PACK_SPECIAL_EN
    logic [3:0]  out_special;
`endif

    always #5 clk = ~clk;

    fp16_sum_packer #(
        .LANES (LANES),
        .PAD   (16'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
`ifdef FP16_PACK_SPECIAL_EN
        .out_special (out_special),
`endif
        .out_last  (out_last)
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [3:0]  spec;
    } word_t;

    word_t       q[$];
    logic [15:0] cur[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic        rdy = 1'b1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic word_t make_word(input logic last);
        word_t w;
        w.data = '0;
        w.keep = '0;
        w.spec = '0;
        w.last = last;
        for (int i = 0; i < cur.size(); i++) begin
            w.data[i*16 +: 16] = cur[i];
            w.keep[i] = 1'b1;
            w.spec[i] = (cur[i][14:10] == 5'h1F);
        end
        return w;
    endfunction

    task automatic verify();
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("out_data", out_data, q[0].data);
            check("out_keep", out_keep, q[0].keep);
            check("out_last", out_last, q[0].last);
`ifdef FP16_PACK_SPECIAL_EN
            check("out_special", out_special, q[0].spec);
`endif
        end
    endtask

    // Called at a negedge; returns at the following negedge after checking.
    task automatic step(input logic v, input logic [15:0] d, input logic l,
                        input logic r, output logic acc);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        acc = v && (q.size() < 2);
        if (q.size() > 0 && r) void'(q.pop_front());
        if (acc) begin
            cur.push_back(d);
            if (l || cur.size() == LANES) begin
                q.push_back(make_word(l));
                cur.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
        verify();
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        logic acc;
        int   k;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 40) begin
            step(1'b1, d, l, rdy, acc);
            k++;
        end
        check("send_acc", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) step(1'b0, 16'h0, 1'b0, rdy, acc);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_data", out_data, 64'h0);
        check("rst_out_keep", out_keep, 4'h0);
        check("rst_out_last", out_last, 1'b0);
        q.delete();
        cur.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        verify();
    endtask

    initial begin
        logic        acc;
        logic        pend;
        logic        v;
        logic [15:0] pd;
        logic        pl;

        @(negedge clk);
        do_reset();

        // full word with last on lane 3
        rdy = 1'b1;
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h4200, 1'b0);
        send(16'h4400, 1'b1);
        check("t1_valid", out_valid, 1'b1);
        check("t1_data", out_data, 64'h4400_4200_4000_3C00);
        check("t1_keep", out_keep, 4'hF);
        check("t1_last", out_last, 1'b1);

        // early close after two lanes
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b1);
        check("t2_data", out_data, 64'h0000_0000_4000_3C00);
        check("t2_keep", out_keep, 4'h3);
        send(16'h4800, 1'b1);
        check("t2_lane0", out_data, 64'h0000_0000_0000_4800);
        check("t2_keep1", out_keep, 4'h1);
        idle(2);

        // backpressure: two words fill the buffer
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) send(16'h1000 + 16'(i), 1'b0);
        check("t3_full", in_ready, 1'b0);
        repeat (3) begin
            step(1'b1, 16'h1008, 1'b0, 1'b0, acc);
            check("t3_stall", acc, 1'b0);
        end
        rdy = 1'b1;
        for (int i = 8; i < 12; i++) send(16'h1000 + 16'(i), 1'b0);
        idle(4);

        // push+pop in ONE: single-lane words back to back
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(16'h2000 + 16'(i), 1'b1);
            check("t4_ready", in_ready, 1'b1);
            check("t4_data", out_data, 64'(16'h2000 + 16'(i)));
        end
        idle(2);

        // reset mid-word with one word buffered
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) send(16'h3000 + 16'(i), 1'b0);
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) send(16'h5000 + 16'(i), 1'b0);
        check("t5_data", out_data, 64'h5003_5002_5001_5000);
        check("t5_keep", out_keep, 4'hF);
        check("t5_last", out_last, 1'b0);
        idle(2);

`ifdef FP16_PACK_SPECIAL_EN
        send(16'h7C00, 1'b0);
        send(16'h7E00, 1'b0);
        send(16'h3C00, 1'b1);
        check("t6_special", out_special, 4'b0011);
        check("t6_keep", out_keep, 4'b0111);
        idle(2);
`endif

        // randomized traffic with source holding unaccepted data
        pend = 1'b0;
        pd = '0;
        pl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                pend = 1'b0;
            end
            if (!pend) begin
                v  = ($urandom_range(0, 3) != 0);
                pd = ($urandom_range(0, 5) == 0) ?
                     (16'h7C00 | 16'($urandom_range(0, 1023))) :
                     16'($urandom);
                pl = ($urandom_range(0, 4) == 0);
            end else begin
                v = 1'b1;
            end
            step(v, pd, pl, ($urandom_range(0, 2) != 0), acc);
            pend = v && !acc;
        end
        rdy = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
